// File: rtl/shared_pkg.sv
// Shared configuration and types for the parametrised synchronous FIFO and its bench.
package shared_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH      = 8;

  typedef logic [$clog2(FIFO_DEPTH):0] count_t;

  typedef enum logic [1:0] {
    WRITE,
    READ,
    WRITE_READ,
    IDLE
  } trans_kind_e;

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer handshake and status bundle of param_sync_fifo.
interface param_sync_fifo_if
  import shared_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CntW-1:0]       count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, count
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage, one synchronous write port and one read port.
// Read port is combinational when FIFO_FWFT_EN is defined, registered otherwise.
module fifo_mem #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 8,
  localparam int unsigned AddrW    = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef FIFO_FWFT_EN
  logic unused_ctrl;
  assign unused_ctrl = ^{rst_ni, re_i};
  assign rdata_o     = mem_q[raddr_i];
`else
  logic [DataWidth-1:0] rdata_q;

  // Holds the last popped word until the next accepted read.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO: pointers, occupancy count and status flags.
// Optional first-word-fall-through read path selected by FIFO_FWFT_EN.
module param_sync_fifo
  import shared_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned AF_MARGIN  = 1,
  parameter int unsigned AE_MARGIN  = 1
) (
  input logic              clk,
  input logic              rst_n,
  param_sync_fifo_if.slave fifo
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfLevel = CntW'(DEPTH - AF_MARGIN);
  localparam logic [CntW-1:0] AeLevel = CntW'(AE_MARGIN);

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  full, empty, wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] rdata;
  trans_kind_e           kind;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when the same-cycle read frees a slot.
  assign wr_accept = fifo.wr_en && (!full || fifo.rd_en);
  assign rd_accept = fifo.rd_en && !empty;

  always_comb begin
    kind = IDLE;
    if (wr_accept && rd_accept) begin
      kind = WRITE_READ;
    end else if (wr_accept) begin
      kind = WRITE;
    end else if (rd_accept) begin
      kind = READ;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (kind)
      WRITE: begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        count_d  = count_q + CntW'(1);
      end
      READ: begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d  = count_q - CntW'(1);
      end
      WRITE_READ: begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      IDLE: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= fifo.wr_en && !wr_accept;
      underflow_q <= fifo.rd_en && !rd_accept;
    end
  end

  fifo_mem #(
    .DataWidth (DATA_WIDTH),
    .Depth     (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo.data_in),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

`ifdef FIFO_FWFT_EN
  assign fifo.data_out = empty ? '0 : rdata;
`else
  assign fifo.data_out = rdata;
`endif

  assign fifo.wr_ack      = wr_ack_q;
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;
  assign fifo.full        = full;
  assign fifo.empty       = empty;
  assign fifo.almostfull  = (count_q >= AfLevel);
  assign fifo.almostempty = (count_q <= AeLevel);
  assign fifo.count       = count_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo against a queue-based reference model.
module tb_param_sync_fifo;
  import shared_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 8;
  localparam int unsigned AFM = 1;
  localparam int unsigned AEM = 1;

  logic clk = 1'b0;
  logic rst_n;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  param_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .AF_MARGIN  (AFM),
    .AE_MARGIN  (AEM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fifo  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue plus the last observed pulse outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ack, m_ovf, m_udf;

  function automatic logic [26:0] obs_vec();
    return {bus.data_out, bus.wr_ack, bus.overflow, bus.underflow, bus.full, bus.empty,
            bus.almostfull, bus.almostempty, bus.count};
  endfunction

  function automatic logic [26:0] exp_vec();
    int n;
    n = q.size();
    return {m_dout, m_ack, m_ovf, m_udf, n == DP, n == 0, n >= DP - AFM, n <= AEM, 4'(n)};
  endfunction

  task automatic step(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] din);
    bit wr_ok, rd_ok;
    rst_n       = ~rst;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = din;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_ack  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = wr && ((q.size() < DP) || rd);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
      m_ack = wr_ok;
      m_ovf = wr && !wr_ok;
      m_udf = rd && !rd_ok;
    end
`ifdef FIFO_FWFT_EN
    m_dout = (q.size() > 0) ? q[0] : '0;
`endif
    #1;
    rst_n     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 16'hFFFF);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    int acks = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'(i));
      if (bus.wr_ack === 1'b1) acks++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (acks !== 8 || bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_summary got acks=%0d full=%b count=%0d ovf=%b want 8 1 8 0",
               acks, bus.full, bus.count, bus.overflow);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b1, 1'b0, 16'hDEAD);
    n_tests++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL overflow got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full_rw();
    step(1'b0, 1'b1, 1'b1, 16'h0009);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL full_rw got %h want %h", obs_vec(), exp_vec());
    end
`ifndef FIFO_FWFT_EN
    n_tests++;
    if (bus.data_out !== 16'h0001 || bus.overflow !== 1'b0 || bus.count !== 4'd8) begin
      n_fail++;
      $display("FAIL full_rw_data got %h want 0001", bus.data_out);
    end
`endif
    for (int i = 2; i <= 9; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
`ifndef FIFO_FWFT_EN
      n_tests++;
      if (bus.data_out !== 16'(i)) begin
        n_fail++;
        $display("FAIL drain_data[%0d] got %h want %h", i, bus.data_out, 16'(i));
      end
`endif
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] held;
    held = bus.data_out;
    step(1'b0, 1'b0, 1'b1, '0);
    n_tests++;
    if (bus.underflow !== 1'b1 || bus.data_out !== held || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL underflow got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 1'b1, 16'h00AA);
    n_tests++;
    if (bus.underflow !== 1'b1 || bus.count !== 4'd1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL empty_rw got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b0, 1'b1, '0);
    n_tests++;
`ifndef FIFO_FWFT_EN
    if (bus.data_out !== 16'h00AA || obs_vec() !== exp_vec()) begin
`else
    if (obs_vec() !== exp_vec()) begin
`endif
      n_fail++;
      $display("FAIL empty_rw_read got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'($urandom));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_wr[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
      step(1'b0, 1'b0, 1'b1, '0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_rd[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.almostempty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_end got empty=%b count=%0d ae=%b want 1 0 1",
               bus.empty, bus.count, bus.almostempty);
    end
  endtask

  task automatic test_random();
    bit rst, wr, rd;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 50);
      step(rst, wr, rd, 16'($urandom));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
    step(1'b1, 1'b1, 1'b0, 16'h5555);
    n_tests++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.data_out !== 16'h0000 ||
        bus.wr_ack !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid got %h want %h", obs_vec(), exp_vec());
    end
`ifdef FIFO_FWFT_EN
    step(1'b0, 1'b1, 1'b0, 16'h1234);
    n_tests++;
    if (bus.data_out !== 16'h1234 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL fwft_show got %h want 1234", bus.data_out);
    end
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    m_dout      = '0;
    m_ack       = 1'b0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_reset();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's fixed-size FIFO.
- Adds generic width/depth, programmable almost-full/almost-empty thresholds, an occupancy count, and write/overflow/underflow status.
- Defined full-plus-read concurrency rule.
- Sits between a producer and consumer on one clock domain; driven by the FIFO_if-style bench.

Parameters:
DATA_WIDTH, 16, width of data_in/data_out
DEPTH, 8, number of entries; power of two, >= 4
AF_MARGIN, 1, almostfull asserts when count >= DEPTH-AF_MARGIN; range 1..DEPTH-2
AE_MARGIN, 1, almostempty asserts when count <= AE_MARGIN; range 1..DEPTH-2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
data_in  in  DATA_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request
data_out  out  DATA_WIDTH  read data
wr_ack  out  1  registered: previous-cycle write accepted
overflow  out  1  registered: previous-cycle write rejected (full)
underflow  out  1  registered: previous-cycle read rejected (empty)
full  out  1  count == DEPTH
empty  out  1  count == 0
almostfull  out  1  count >= DEPTH-AF_MARGIN
almostempty  out  1  count <= AE_MARGIN
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-low (rst_n).
- The polarity and synchronicity are fixed.

Reset:
- On clk edge with rst_n=0: wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
- Storage array is not reset.
- Reset overrides any concurrent wr_en/rd_en; a reset mid-stream discards all contents.

Pointers and count:
- Pointers are $clog2(DEPTH) bits; they wrap naturally from DEPTH-1 to 0.
- count changes by +1 (write only), -1 (read only), or 0 (both or neither).

Write (wr_en=1):
- Accepted if !full, or if full and rd_en=1.
- On accept: mem[wr_ptr]<=data_in, wr_ptr++, wr_ack=1 next cycle.
- On reject: overflow=1 next cycle, no state change.

Read (rd_en=1):
- Accepted if !empty.
- Default (non-FWFT): data_out<=mem[rd_ptr], rd_ptr++; data appears 1 cycle after the rd_en edge.
- On reject: underflow=1 next cycle; data_out holds its previous value.

Simultaneous wr_en and rd_en:
- Not full, not empty: both performed, count unchanged.
- Full: both performed; the read takes the oldest entry, the write fills the freed slot; no overflow.
- Empty: write only, underflow=1, count 0->1.

Status outputs:
- wr_ack, overflow, underflow are single-cycle pulses; each deasserts on any cycle without the corresponding event.
- full, empty, almostfull, almostempty are combinational from count; valid in the same cycle as count.

Optional Feature:
FIFO_FWFT_EN (first-word-fall-through)
- Defined:
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - rd_en acknowledges/pops the shown word; read latency is 0.
  - All flags and the concurrency rules are unchanged.
- Undefined: registered read with 1-cycle latency, as described in Behaviour.

Decomposition:
- Shared package (shared_pkg):
  - Default-configuration localparams FIFO_DATA_WIDTH=16 and FIFO_DEPTH=8.
  - typedef of the count type, sized from FIFO_DEPTH.
  - Enum for transaction kind {WRITE, READ, WRITE_READ, IDLE}, reused by the bench transaction class.
- Natural sub-module: fifo_mem, a DEPTH x DATA_WIDTH storage array with one synchronous write port and one read port.
  - The read port is registered or combinational, selected by FIFO_FWFT_EN.
  - The top level holds pointers, count and flags.

Test Plan (DATA_WIDTH=16, DEPTH=8, AF_MARGIN=1, AE_MARGIN=1, non-FWFT unless noted):
1. Reset, then 8 writes of 0x0001..0x0008 -> wr_ack pulses 8 times, count=8, full=1, almostfull high from count=7, overflow=0.
2. From full, one write of 0xDEAD -> overflow=1 next cycle, count stays 8, 0xDEAD never read.
3. From full, wr_en=rd_en=1 with data_in=0x0009 -> data_out=0x0001 next cycle, count=8, no overflow; 8 further reads return 0x0002..0x0009.
4. From empty, rd_en=1 alone -> underflow=1 next cycle, data_out unchanged, count=0; then wr_en=rd_en=1 with 0x00AA -> underflow=1, count=1, next read returns 0x00AA.
5. Write 12 and read 12 interleaved (pointer wrap) -> data order preserved; empty=1 and count=0 at end; almostempty high at count<=1.
6. Fill with 5 words, assert rst_n=0 for one edge together with wr_en=1 -> count=0, empty=1, data_out=0, wr_ack=0. With FIFO_FWFT_EN, after a single write of 0x1234, data_out=0x1234 with no rd_en.
